// File: rtl/delta_scan_controller.sv
// delta_scan_controller: raster-scans a signed 2-D window and paces each point by the delta generator latency
//   i_clk, i_rst_n                   : clock, asynchronous active-low reset
//   i_start, i_x_min..i_y_max, i_step : scan request and window, latched on the start edge
//   o_p_x, o_p_y, o_point_idx        : current focus point and its index in the scan
//   o_valid, i_ready                 : point handshake, a transfer advances the raster
//   o_busy, o_done                   : scan in progress, one-cycle end-of-scan pulse
//   DELTA_SCAN_ABORT_EN              : when defined adds i_abort to cancel a running scan
module delta_scan_controller #(
    parameter int GEN_LATENCY = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic signed [7:0] i_x_min,
    input  logic signed [7:0] i_x_max,
    input  logic signed [7:0] i_y_min,
    input  logic signed [7:0] i_y_max,
    input  logic        [3:0] i_step,
    input  logic              i_ready,
`ifdef DELTA_SCAN_ABORT_EN
    input  logic              i_abort,
`endif
    output logic signed [7:0] o_p_x,
    output logic signed [7:0] o_p_y,
    output logic              o_valid,
    output logic       [15:0] o_point_idx,
    output logic              o_busy,
    output logic              o_done
);
    typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;
    state_t state_q, state_d;
    logic signed [7:0] p_x_q, p_x_d, p_y_q, p_y_d;
    logic signed [7:0] x_min_q, x_min_d, x_max_q, x_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
    logic [3:0] step_q, step_d, cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic signed [8:0] nx, ny;
    logic abort;
`ifdef DELTA_SCAN_ABORT_EN
    assign abort = i_abort & busy_q;
`else
    assign abort = 1'b0;
`endif
    // one extra bit keeps points near +127 from wrapping negative
    assign nx = {p_x_q[7], p_x_q} + {5'd0, step_q};
    assign ny = {p_y_q[7], p_y_q} + {5'd0, step_q};
    always_comb begin
        state_d = state_q;
        p_x_d   = p_x_q;
        p_y_d   = p_y_q;
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_min_d = y_min_q;
        y_max_d = y_max_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // a start coinciding with the done pulse is dropped
                    if (i_start && !done_q) begin
                        x_min_d = i_x_min;
                        x_max_d = i_x_max;
                        y_min_d = i_y_min;
                        y_max_d = i_y_max;
                        step_d  = (i_step == 4'd0) ? 4'd1 : i_step;
                        p_x_d   = i_x_min;
                        p_y_d   = i_y_min;
                        idx_d   = 16'd0;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b1;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (x_min_q > x_max_q || y_min_q > y_max_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (cnt_q == 4'(GEN_LATENCY - 1)) begin
                        cnt_d   = 4'd0;
                        valid_d = 1'b1;
                        state_d = VALID;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                VALID: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        if (nx <= x_max_q) begin
                            p_x_d   = nx[7:0];
                            idx_d   = idx_q + 16'd1;
                            state_d = SETTLE;
                        end else if (ny <= y_max_q) begin
                            p_x_d   = x_min_q;
                            p_y_d   = ny[7:0];
                            idx_d   = idx_q + 16'd1;
                            state_d = SETTLE;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            p_x_q   <= '0;
            p_y_q   <= '0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            step_q  <= 4'd1;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_x_q   <= p_x_d;
            p_y_q   <= p_y_d;
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign o_p_x       = p_x_q;
    assign o_p_y       = p_y_q;
    assign o_valid     = valid_q;
    assign o_point_idx = idx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
endmodule

// File: tb/tb_delta_scan_controller.sv
// tb_delta_scan_controller: scoreboard bench for delta_scan_controller
module tb_delta_scan_controller;
    localparam int LAT = 3;
    typedef struct {
        logic signed [7:0] x;
        logic signed [7:0] y;
        logic [15:0] i;
    } pt_t;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1, abort = 1'b0;
    logic signed [7:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;
    logic [3:0] step = 4'd1;
    logic signed [7:0] p_x, p_y;
    logic valid, busy, done;
    logic [15:0] idx;
    int checks = 0, failures = 0, done_seen = 0, settle = 0;
    logic prev_valid = 1'b0;
    pt_t exp_q[$];
    pt_t e;
    always #5 clk = ~clk;
    delta_scan_controller #(.GEN_LATENCY(LAT)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_x_min(x_min),
        .i_x_max(x_max),
        .i_y_min(y_min),
        .i_y_max(y_max),
        .i_step(step),
        .i_ready(ready),
`ifdef DELTA_SCAN_ABORT_EN
        .i_abort(abort),
`endif
        .o_p_x(p_x),
        .o_p_y(p_y),
        .o_valid(valid),
        .o_point_idx(idx),
        .o_busy(busy),
        .o_done(done)
    );
    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int x, input int y, input int i);
        pt_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.i = 16'(i);
        exp_q.push_back(p);
    endtask
    task automatic go(input int xa, input int xb, input int ya, input int yb, input int s);
        x_min = 8'(xa);
        x_max = 8'(xb);
        y_min = 8'(ya);
        y_max = 8'(yb);
        step  = 4'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        x_min = -8'sd1;
        x_max = -8'sd100;
        y_min = 8'sd50;
        y_max = 8'sd60;
        step  = 4'd7;
    endtask
    task automatic wait_done(input string name, input int n0);
        int k = 0;
        while (done_seen == n0 && k < 2000) begin
            tick();
            k++;
        end
        check(name, done_seen, n0 + 1);
    endtask
    task automatic wait_valid(input string name);
        int k = 0;
        while (!valid && k < 50) begin
            tick();
            k++;
        end
        check(name, valid, 1);
    endtask
    // monitor: latency of each point and every transfer against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            settle = 0;
            prev_valid = 1'b0;
        end else begin
            if (busy && !valid) settle++;
            if (valid && !prev_valid) check("settle_latency", settle, LAT);
            if (valid && ready && !abort) begin
                settle = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer actual=(%0d,%0d,%0d) required=none", p_x, p_y, idx);
                end else begin
                    e = exp_q.pop_front();
                    check("point_x", p_x, e.x);
                    check("point_y", p_y, e.y);
                    check("point_idx", idx, e.i);
                end
            end
            if (!busy) settle = 0;
            if (done) done_seen++;
            prev_valid = valid;
        end
    end
    initial begin
        int n0;
        #2;
        check("rst_px", p_x, 0);
        check("rst_py", p_y, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", idx, 0);
        tick();
        rst_n = 1'b1;
        tick();
        // basic 3-point scan; a start held from mid-scan through the done pulse is ignored
        n0 = done_seen;
        push(3, -26, 0);
        push(4, -26, 1);
        push(5, -26, 2);
        go(3, 5, -26, -26, 1);
        tick();
        tick();
        start = 1'b1;
        x_min = 8'sd20;
        wait_done("done_basic", n0);
        start = 1'b0;
        tick();
        check("busy_after_done", busy, 0);
        check("hold_px", p_x, 5);
        check("hold_py", p_y, -26);
        check("hold_idx", idx, 2);
        tick();
        check("done_once", done_seen, n0 + 1);
        check("no_restart", busy, 0);
        check("left_basic", exp_q.size(), 0);
        // full signed x range, step 15
        n0 = done_seen;
        for (int k = 0; k < 18; k++) push(-128 + 15 * k, 0, k);
        go(-128, 127, 0, 0, 15);
        wait_done("done_wide", n0);
        check("wide_last_x", p_x, 127);
        check("left_wide", exp_q.size(), 0);
        // back-pressure with step 0 treated as 1
        n0 = done_seen;
        ready = 1'b0;
        push(0, 0, 0);
        push(1, 0, 1);
        push(0, 1, 2);
        push(1, 1, 3);
        go(0, 1, 0, 1, 0);
        wait_valid("bp_valid");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_valid", valid, 1);
            check("bp_hold_x", p_x, 0);
            check("bp_hold_y", p_y, 0);
        end
        ready = 1'b1;
        wait_done("done_bp", n0);
        check("left_bp", exp_q.size(), 0);
        // inverted window
        tick();
        n0 = done_seen;
        go(10, 5, 0, 0, 1);
        check("inv_busy", busy, 1);
        check("inv_valid", valid, 0);
        tick();
        check("inv_done", done, 1);
        check("inv_busy_clear", busy, 0);
        check("inv_px", p_x, 10);
        check("inv_py", p_y, 0);
        tick();
        check("inv_done_pulse", done, 0);
        check("inv_done_count", done_seen, n0 + 1);
        // async reset mid-settle
        tick();
        go(7, 9, 2, 2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_px", p_x, 0);
        check("mid_rst_py", p_y, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        n0 = done_seen;
        tick();
        tick();
        tick();
        check("rst_no_done", done_seen, n0);
        check("rst_idle", busy, 0);
        push(3, -26, 0);
        push(4, -26, 1);
        push(5, -26, 2);
        go(3, 5, -26, -26, 1);
        check("restart_idx", idx, 0);
        wait_done("done_restart", n0);
        check("left_restart", exp_q.size(), 0);
`ifdef DELTA_SCAN_ABORT_EN
        tick();
        n0 = done_seen;
        ready = 1'b1;
        go(0, 2, 0, 0, 1);
        wait_valid("abort_valid");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_valid_clear", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_px", p_x, 0);
        check("abort_idx", idx, 0);
        tick();
        check("abort_done_count", done_seen, n0 + 1);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
